// File: rtl/gate_truth_table_bist_if.sv
// Purpose: bundles the BIST request/result signals and the gate-under-test pins.
// Latency: none, wiring only.
// Backpressure: none; start is a level request and done is a single-cycle pulse.
//
// Port summary:
//   start            requester -> BIST   request a run (ignored while busy)
//   dut_a, dut_b     BIST -> gate        gate inputs, registered
//   dut_o            gate -> BIST        gate output, combinational from dut_a/dut_b
//   busy, done       BIST -> requester   run in progress / one-cycle completion pulse
//   pass             BIST -> requester   last run had zero mismatches
//   fail_count       BIST -> requester   mismatches in the last run (0..4)
//   first_fail_index BIST -> requester   {a,b} of the first mismatch, 0 when none
interface gate_truth_table_bist_if;
    logic       start;
    logic       dut_a;
    logic       dut_b;
    logic       dut_o;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] fail_count;
    logic [1:0] first_fail_index;

    // The BIST engine itself.
    modport slave (
        input  start,
        input  dut_o,
        output dut_a,
        output dut_b,
        output busy,
        output done,
        output pass,
        output fail_count,
        output first_fail_index
    );

    // The environment: whoever requests runs and hosts the gate under test.
    modport master (
        output start,
        output dut_o,
        input  dut_a,
        input  dut_b,
        input  busy,
        input  done,
        input  pass,
        input  fail_count,
        input  first_fail_index
    );
endinterface

// File: rtl/gate_truth_table_bist.sv
// Purpose: sweeps a two-input gate through 00,01,10,11 and checks it against the OP truth table.
// Latency: each vector held SETTLE_CYCLES+1 cycles; done pulses 4*(SETTLE_CYCLES+1) cycles after start.
// Backpressure: none; start is ignored while busy, and accepted in the done cycle for back-to-back runs.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset; aborts a run without a done pulse
//   bus  slave side of gate_truth_table_bist_if (request, gate pins, results)
// Parameters:
//   SETTLE_CYCLES  extra hold cycles per vector before sampling dut_o (0..15)
//   OP             expected function: 0 AND, 1 OR, 2 XOR, 3 NAND
module gate_truth_table_bist #(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [1:0]  OP            = 2'd0
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_truth_table_bist_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);

    state_t     state;
    logic [1:0] k;
    logic [3:0] settle_cnt;

    logic       dut_a_q;
    logic       dut_b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [2:0] fail_count_q;
    logic [1:0] first_fail_q;

    // Expected gate output for vector {a,b} = idx.
    function automatic logic expect_bit(input logic [1:0] idx);
        case (OP)
            2'd0:    return idx[1] & idx[0];
            2'd1:    return idx[1] | idx[0];
            2'd2:    return idx[1] ^ idx[0];
            default: return ~(idx[1] & idx[0]);
        endcase
    endfunction

    // The vector on dut_a/dut_b always equals k while in DRIVE, so the
    // comparison can use k directly instead of the registered pins.
    logic       mismatch;
    logic [2:0] fail_count_nxt;
    logic [1:0] k_inc;

    assign mismatch       = (bus.dut_o != expect_bit(k));
    assign fail_count_nxt = fail_count_q + 3'(mismatch);
    assign k_inc          = k + 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= 2'd0;
            settle_cnt   <= 4'd0;
            dut_a_q      <= 1'b0;
            dut_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_count_q <= 3'd0;
            first_fail_q <= 2'd0;
        end else begin
            case (state)
                // DONE behaves like IDLE for start acceptance, which gives
                // back-to-back runs when start is held high.
                IDLE, DONE: begin
                    done_q  <= 1'b0;
                    dut_a_q <= 1'b0;
                    dut_b_q <= 1'b0;
                    if (bus.start) begin
                        state        <= DRIVE;
                        k            <= 2'd0;
                        settle_cnt   <= SETTLE_LOAD;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        fail_count_q <= 3'd0;
                        first_fail_q <= 2'd0;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                DRIVE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        // At most four samples, so fail_count never wraps.
                        fail_count_q <= fail_count_nxt;
                        if (mismatch && (fail_count_q == 3'd0)) begin
                            first_fail_q <= k;
                        end
                        if (k != 2'd3) begin
                            k          <= k_inc;
                            settle_cnt <= SETTLE_LOAD;
                            dut_a_q    <= k_inc[1];
                            dut_b_q    <= k_inc[0];
                        end else begin
                            state   <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dut_a_q <= 1'b0;
                            dut_b_q <= 1'b0;
                            // Uses the post-update count so pass is valid in the done cycle.
                            pass_q  <= (fail_count_nxt == 3'd0);
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    dut_a_q <= 1'b0;
                    dut_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_a            = dut_a_q;
    assign bus.dut_b            = dut_b_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.fail_count       = fail_count_q;
    assign bus.first_fail_index = first_fail_q;

endmodule

// File: tb/tb_gate_truth_table_bist.sv
// Bench for gate_truth_table_bist: three instances with different SETTLE_CYCLES/OP,
// each wrapped around a programmable gate (4-entry truth table, bit {a,b}).
module tb_gate_truth_table_bist;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NI-1:0]  start_s;
    logic [3:0]     tt_s [NI];

    logic [NI-1:0]  o_a, o_b, o_busy, o_done, o_pass;
    logic [2:0]     o_fc  [NI];
    logic [1:0]     o_ffi [NI];

    int total = 0;
    int bad   = 0;

    gate_truth_table_bist_if if0 ();
    gate_truth_table_bist_if if1 ();
    gate_truth_table_bist_if if2 ();

    assign if0.start = start_s[0];
    assign if1.start = start_s[1];
    assign if2.start = start_s[2];
    assign if0.dut_o = tt_s[0][{if0.dut_a, if0.dut_b}];
    assign if1.dut_o = tt_s[1][{if1.dut_a, if1.dut_b}];
    assign if2.dut_o = tt_s[2][{if2.dut_a, if2.dut_b}];

    assign o_a[0] = if0.dut_a;  assign o_a[1] = if1.dut_a;  assign o_a[2] = if2.dut_a;
    assign o_b[0] = if0.dut_b;  assign o_b[1] = if1.dut_b;  assign o_b[2] = if2.dut_b;
    assign o_busy[0] = if0.busy; assign o_busy[1] = if1.busy; assign o_busy[2] = if2.busy;
    assign o_done[0] = if0.done; assign o_done[1] = if1.done; assign o_done[2] = if2.done;
    assign o_pass[0] = if0.pass; assign o_pass[1] = if1.pass; assign o_pass[2] = if2.pass;
    assign o_fc[0] = if0.fail_count; assign o_fc[1] = if1.fail_count; assign o_fc[2] = if2.fail_count;
    assign o_ffi[0] = if0.first_fail_index; assign o_ffi[1] = if1.first_fail_index;
    assign o_ffi[2] = if2.first_fail_index;

    gate_truth_table_bist #(.SETTLE_CYCLES(1), .OP(2'd0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    gate_truth_table_bist #(.SETTLE_CYCLES(0), .OP(2'd3)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    gate_truth_table_bist #(.SETTLE_CYCLES(3), .OP(2'd2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    function automatic int settle_of(input int i);
        case (i)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int op_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit op_fn(input int op, input bit a, input bit b);
        case (op)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return !(a & b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input int i, input string tag);
        chk({tag, "_busy"}, 8'(o_busy[i]), 8'd0);
        chk({tag, "_done"}, 8'(o_done[i]), 8'd0);
        chk({tag, "_pass"}, 8'(o_pass[i]), 8'd0);
        chk({tag, "_fc"},   8'(o_fc[i]),   8'd0);
        chk({tag, "_ffi"},  8'(o_ffi[i]),  8'd0);
        chk({tag, "_a"},    8'(o_a[i]),    8'd0);
        chk({tag, "_b"},    8'(o_b[i]),    8'd0);
    endtask

    // One full run on instance i with gate truth table tt. Cycle n is the cycle
    // after edge n (edge 0 samples start). Random start pokes are injected mid-run.
    task automatic run(input int i, input logic [3:0] tt, input string tag,
                       input int hand_fc, input int hand_ffi);
        int s   = settle_of(i);
        int len = 4 * (s + 1);
        bit mm [4];
        int fc, ffi, kv;
        bit seen;
        for (int k = 0; k < 4; k++) begin
            mm[k] = (tt[k] != op_fn(op_of(i), k[1], k[0]));
        end
        tt_s[i] = tt;
        @(negedge clk);
        start_s[i] = 1'b1;
        @(posedge clk);
        #1 start_s[i] = 1'b0;
        for (int n = 0; n <= len + 1; n++) begin
            @(negedge clk);
            fc = 0; ffi = 0; seen = 0;
            for (int k = 0; k < 4; k++) begin
                if (mm[k] && ((k + 1) * (s + 1) <= n)) begin
                    if (!seen) ffi = k;
                    seen = 1;
                    fc++;
                end
            end
            if (n < len) begin
                kv = n / (s + 1);
                chk($sformatf("%s_n%0d_busy", tag, n), 8'(o_busy[i]), 8'd1);
                chk($sformatf("%s_n%0d_done", tag, n), 8'(o_done[i]), 8'd0);
                chk($sformatf("%s_n%0d_a", tag, n), 8'(o_a[i]), 8'(kv[1]));
                chk($sformatf("%s_n%0d_b", tag, n), 8'(o_b[i]), 8'(kv[0]));
            end else begin
                chk($sformatf("%s_n%0d_busy", tag, n), 8'(o_busy[i]), 8'd0);
                chk($sformatf("%s_n%0d_done", tag, n), 8'(o_done[i]), 8'(n == len));
                chk($sformatf("%s_n%0d_a", tag, n), 8'(o_a[i]), 8'd0);
                chk($sformatf("%s_n%0d_b", tag, n), 8'(o_b[i]), 8'd0);
                chk($sformatf("%s_n%0d_pass", tag, n), 8'(o_pass[i]), 8'(fc == 0));
            end
            chk($sformatf("%s_n%0d_fc", tag, n), 8'(o_fc[i]), 8'(fc));
            chk($sformatf("%s_n%0d_ffi", tag, n), 8'(o_ffi[i]), 8'(ffi));
            if (n >= 1 && n <= len - 2) start_s[i] = 1'($urandom_range(0, 1));
            else                        start_s[i] = 1'b0;
        end
        if (hand_fc >= 0) begin
            chk({tag, "_hand_fc"},  8'(o_fc[i]),  8'(hand_fc));
            chk({tag, "_hand_ffi"}, 8'(o_ffi[i]), 8'(hand_ffi));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_at [3];
        int dones;
        rst     = 1'b1;
        start_s = '0;
        for (int i = 0; i < NI; i++) tt_s[i] = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) check_reset_vals(i, $sformatf("rst%0d", i));
        rst = 1'b0;

        // Directed truth tables: bit k is the gate output for {a,b}=k.
        run(0, 4'b1000, "and_ok",    0, 0);
        run(0, 4'b1110, "or_as_and", 2, 1);
        run(0, 4'b1111, "sa1_and",   3, 0);
        run(1, 4'b1111, "sa1_nand",  1, 3);
        run(1, 4'b0111, "nand_ok",   0, 0);
        run(2, 4'b0110, "xor_ok",    0, 0);
        run(2, 4'b0000, "sa0_xor",   2, 1);

        // Start held high: done every 4*(S+1)+1 cycles on instance 0 (S=1).
        tt_s[0] = 4'b1000;
        @(negedge clk);
        start_s[0] = 1'b1;
        dones = 0;
        for (int c = 0; c < 200 && dones < 3; c++) begin
            @(negedge clk);
            if (o_done[0]) begin
                d_at[dones] = c;
                dones++;
                chk($sformatf("cont_pass%0d", dones), 8'(o_pass[0]), 8'd1);
            end
        end
        start_s[0] = 1'b0;
        chk("cont_ndone", 8'(dones), 8'd3);
        if (dones == 3) begin
            chk("cont_d0", 8'(d_at[0]), 8'd8);
            chk("cont_d1", 8'(d_at[1]), 8'd17);
            chk("cont_d2", 8'(d_at[2]), 8'd26);
        end
        @(negedge clk);
        chk("cont_idle_busy", 8'(o_busy[0]), 8'd0);

        // Reset during vector 2 on instance 0 with a faulty gate.
        tt_s[0] = 4'b1110;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(posedge clk);
        #1 start_s[0] = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_vec_a", 8'(o_a[0]), 8'd1);
        chk("mid_vec_b", 8'(o_b[0]), 8'd0);
        chk("mid_fc",    8'(o_fc[0]), 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_vals(0, "midrst");
        begin
            int seen_done = 0;
            int seen_busy = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (o_done[0]) seen_done++;
                if (o_busy[0]) seen_busy++;
            end
            chk("midrst_nodone", 8'(seen_done), 8'd0);
            chk("midrst_nobusy", 8'(seen_busy), 8'd0);
        end
        run(0, 4'b1000, "post_rst", 0, 0);

        // Random gates on random instances, checked by the run model.
        for (int r = 0; r < 8; r++) begin
            int unsigned inst = $urandom_range(0, NI - 1);
            logic [3:0] tt = 4'($urandom);
            run(int'(inst), tt, $sformatf("rnd%0d", r), -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_bist.md
# gate_truth_table_bist

Sequential built-in self-test driver for the two-input gates in the combinational section, including the mux-built AND gate. It sits directly around the gate under test:
- Upstream, it sweeps inputs `a`/`b` through all four combinations.
- Downstream, it samples the gate output and compares it with the expected truth table.
- It reports pass/fail, the number of mismatches and the first failing vector.

## Interface
Reset is synchronous and active-high, on a single clock. Parameters:
- `SETTLE_CYCLES`, default 1: extra cycles each vector is held before `dut_o` is sampled; legal range 0..15.
- `OP`, default 2'd0: expected function, 0 = AND, 1 = OR, 2 = XOR, 3 = NAND.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request a test run; sampled only when not busy.
- `dut_a` output 1: drives gate input `a`.
- `dut_b` output 1: drives gate input `b`.
- `dut_o` input 1: gate output, combinational from `dut_a`/`dut_b`.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle pulse when a run completes.
- `pass` output 1: last run had zero mismatches; held until the next accepted `start` or reset.
- `fail_count` output 3: mismatches in the last run, 0..4.
- `first_fail_index` output 2: vector index `{a,b}` of the first mismatch; 0 when `pass` = 1.

## Operation
- Vector index `k` runs 0..3, with `dut_a` = `k[1]` and `dut_b` = `k[0]`. The order is 00, 01, 10, 11.
- Expected value `e(k)` = `OP` function of `(k[1], k[0])`. A mismatch is `dut_o` != `e(k)`.
- FSM states:
  - IDLE: `busy`=0, `dut_a`=`dut_b`=0.
    - `start`=1 → DRIVE with `k`=0 and the settle counter loaded with `SETTLE_CYCLES`.
    - `pass`, `fail_count` and `first_fail_index` are cleared on that same edge.
  - DRIVE: `busy`=1 and vector `k` is driven.
    - If counter ≠ 0: decrement and stay.
    - If counter = 0: sample `dut_o`, update the results, then:
      - `k`<3 → `k`+1, reload the counter, stay in DRIVE.
      - `k`=3 → DONE.
  - DONE: `done`=1 and `busy`=0 for exactly one cycle.
    - `pass` = (`fail_count` == 0) becomes visible this cycle.
    - Next state is IDLE, or DRIVE if `start`=1 (back-to-back run accepted).
- Result update on each sample:
  - On mismatch: `fail_count`+1, and if it was 0, `first_fail_index` ← `k`.
  - `fail_count` cannot exceed 4, so no saturation logic is needed.
- `start` while in DRIVE is ignored, with no queuing.
- `dut_a`/`dut_b` are registered outputs and are glitch-free within a vector.
- `dut_a`/`dut_b` return to 0 in DONE and IDLE.

## Timing
- Reset values: `dut_a`=0, `dut_b`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `first_fail_index`=0, state IDLE.
- `rst`=1 at any edge, including mid-run, forces the reset values on that edge. The partial run is discarded and `done` is not pulsed.
- Edge numbering: let edge 0 be the edge that samples `start`=1 in IDLE.
- After edge 0: `busy`=1 and vector 0 is driven.
- Each vector is held for `SETTLE_CYCLES`+1 cycles. `dut_o` is sampled at the last edge of that hold.
- Vector `k` is sampled at edge (`k`+1)·(`SETTLE_CYCLES`+1).
- `done`=1 during the cycle after edge 4·(`SETTLE_CYCLES`+1).
  - With the default `SETTLE_CYCLES`=1, `busy` is high after edges 0..7 and `done` is high after edge 8.
- `fail_count`/`first_fail_index` update one cycle after each sampling edge and may be observed mid-run.
- `pass` is only valid from the `done` cycle onward.

## Test plan
- Correct AND gate, `OP`=0, `SETTLE_CYCLES`=1, `start` pulsed at edge 0 → `done` pulse after edge 8 with `pass`=1, `fail_count`=0 and `first_fail_index`=0. `dut_a`/`dut_b` follow 00,00,01,01,10,10,11,11.
- OR gate wired in, `OP`=0 → mismatches at vectors 1 and 2, giving `pass`=0, `fail_count`=2 and `first_fail_index`=1.
- `dut_o` stuck at 1, `OP`=0 → `fail_count`=3, `first_fail_index`=0. The same stuck-at-1 with `OP`=3 (NAND) → `fail_count`=1, `first_fail_index`=3.
- `SETTLE_CYCLES`=0 → each vector is held one cycle and `done` appears after edge 4. `SETTLE_CYCLES`=3 → `done` appears after edge 16.
- `start` held high continuously → repeated runs with `done` every 4·(`SETTLE_CYCLES`+1)+1 cycles. Pulses of `start` during DRIVE do not restart or extend the run.
- `rst` asserted for one edge during vector 2 → all outputs take reset values on the next cycle and no `done` is pulsed. A subsequent `start` produces a clean, full run.
